// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - PC, imem request handshake and IF/ID register with one-entry skid buffer
// Optional perf counters: define IF_PERF_CNT_EN to add fetch_cnt_o / stall_cnt_o.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [15:0] imm_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;
  logic        unused_redirect_bits;

  assign pc_plus4             = pc + 32'd4;
  assign imem_addr_o          = pc;
  assign imm_o                = instr_o[15:0];
  assign unused_redirect_bits = ^redirect_pc_i[1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc         <= {RESET_PC[31:2], 2'b00};
      instr_o    <= NOP_INSTR;
      pc_plus4_o <= 32'd0;
      valid_o    <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc4   <= 32'd0;
      state      <= BOOT;
      imem_req_o <= 1'b0;
    end else if (redirect_i) begin
      // Redirect discards any in-flight ack and the skid entry; stall is ignored.
      pc         <= {redirect_pc_i[31:2], 2'b00};
      instr_o    <= NOP_INSTR;
      valid_o    <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc4   <= 32'd0;
      state      <= REQ;
      imem_req_o <= 1'b1;
    end else begin
      case (state)
        BOOT: begin
          state      <= REQ;
          imem_req_o <= 1'b1;
        end
        REQ: begin
          if (imem_ack_i && !stall_i) begin
            instr_o    <= imem_data_i;
            pc_plus4_o <= flush_i ? pc_plus4_o : pc_plus4;
            valid_o    <= 1'b1;
            pc         <= pc_plus4;
          end else if (imem_ack_i) begin
            // Decode is stalled: park the returned word until it can accept it.
            skid_instr <= imem_data_i;
            skid_pc4   <= pc_plus4;
            state      <= HOLD;
            imem_req_o <= 1'b0;
          end else if (!stall_i) begin
            instr_o <= NOP_INSTR;
            valid_o <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            instr_o    <= skid_instr;
            pc_plus4_o <= flush_i ? pc_plus4_o : skid_pc4;
            valid_o    <= 1'b1;
            pc         <= pc_plus4;
            skid_instr <= NOP_INSTR;
            skid_pc4   <= 32'd0;
            state      <= REQ;
            imem_req_o <= 1'b1;
          end
        end
        default: begin
          state      <= BOOT;
          imem_req_o <= 1'b0;
        end
      endcase
      if (flush_i) begin
        instr_o <= NOP_INSTR;
        valid_o <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic fetch_inc;

  assign fetch_inc = !redirect_i && !flush_i && !stall_i &&
                     (((state == REQ) && imem_ack_i) || (state == HOLD));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_cnt_o <= 32'd0;
      stall_cnt_o <= 32'd0;
    end else begin
      if (fetch_inc && (fetch_cnt_o != 32'hFFFF_FFFF))
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (stall_i && valid_o && (stall_cnt_o != 32'hFFFF_FFFF))
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - directed self-checking bench for instr_fetch_stage
module tb_instr_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ack, stall, flush, redirect;
  logic [31:0] data, redirect_pc;
  logic        req;
  logic [31:0] addr, instr, pc4;
  logic [15:0] imm;
  logic        valid;

  logic        b_rst, b_ack;
  logic [31:0] b_data;
  logic        b_req;
  logic [31:0] b_addr, b_instr, b_pc4;
  logic [15:0] b_imm;
  logic        b_valid;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'd0;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, b_fetch_cnt, b_stall_cnt;
`endif

  instr_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
    .stall_i(stall), .flush_i(flush), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_o(instr), .imm_o(imm), .pc_plus4_o(pc4), .valid_o(valid)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt_o(fetch_cnt), .stall_cnt_o(stall_cnt)
`endif
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut_wrap (
    .clk_i(clk), .rst_i(b_rst),
    .imem_req_o(b_req), .imem_addr_o(b_addr), .imem_ack_i(b_ack), .imem_data_i(b_data),
    .stall_i(zero1), .flush_i(zero1), .redirect_i(zero1), .redirect_pc_i(zero32),
    .instr_o(b_instr), .imm_o(b_imm), .pc_plus4_o(b_pc4), .valid_o(b_valid)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt_o(b_fetch_cnt), .stall_cnt_o(b_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; ack = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    data = 32'd0; redirect_pc = 32'd0;
    b_rst = 1'b0; b_ack = 1'b0; b_data = 32'd0;

    // Reset held two cycles
    tick(); tick();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_req", 32'(req), 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_pc4", pc4, 32'd0);

    // Release: one BOOT cycle, then request at 0x0
    rst = 1'b1;
    check("boot_req_pre", 32'(req), 32'd0);
    tick();
    check("boot_req", 32'(req), 32'd1);
    check("boot_addr", addr, 32'd0);

    // Fetch 0x0 and 0x4
    ack = 1'b1; data = 32'h2008_FFFF;
    tick();
    check("f0_instr", instr, 32'h2008_FFFF);
    check("f0_imm", 32'(imm), 32'h0000_FFFF);
    check("f0_pc4", pc4, 32'h4);
    check("f0_valid", 32'(valid), 32'd1);
    check("f0_addr", addr, 32'h4);
    data = 32'h1111_1111;
    tick();
    check("f1_instr", instr, 32'h1111_1111);
    check("f1_addr", addr, 32'h8);
    check("f1_pc4", pc4, 32'h8);

    // Stall with ack at 0x8 -> HOLD
    stall = 1'b1; data = 32'h2222_2222;
    tick();
    check("hold_req", 32'(req), 32'd0);
    check("hold_instr", instr, 32'h1111_1111);
    check("hold_addr", addr, 32'h8);
    check("hold_valid", 32'(valid), 32'd1);
    stall = 1'b0; ack = 1'b0; data = 32'hDEAD_BEEF;
    tick();
    check("unhold_instr", instr, 32'h2222_2222);
    check("unhold_pc4", pc4, 32'hC);
    check("unhold_addr", addr, 32'hC);
    check("unhold_req", 32'(req), 32'd1);

    // HOLD again at 0xC, then redirect drops the skid entry
    ack = 1'b1; stall = 1'b1; data = 32'h3333_3333;
    tick();
    check("hold2_req", 32'(req), 32'd0);
    ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h43;
    tick();
    check("redir_valid", 32'(valid), 32'd0);
    check("redir_instr", instr, 32'd0);
    check("redir_addr", addr, 32'h40);
    check("redir_req", 32'(req), 32'd1);
    check("redir_pc4", pc4, 32'hC);
    redirect = 1'b0; stall = 1'b0;
    tick();
    check("noack_bubble_instr", instr, 32'd0);
    check("noack_addr", addr, 32'h40);
    ack = 1'b1; data = 32'h4444_4444;
    tick();
    check("f40_instr", instr, 32'h4444_4444);
    check("f40_pc4", pc4, 32'h44);
    check("f40_addr", addr, 32'h44);

    // Flush and stall together: bubble, PC unchanged
    ack = 1'b0; flush = 1'b1; stall = 1'b1;
    tick();
    check("fl_valid", 32'(valid), 32'd0);
    check("fl_instr", instr, 32'd0);
    check("fl_addr", addr, 32'h44);
    check("fl_pc4", pc4, 32'h44);
    flush = 1'b0;
    tick();
    check("stall_noack_valid", 32'(valid), 32'd0);

    // Flush with ack: PC advances, word dropped, pc_plus4 held
    stall = 1'b0; flush = 1'b1; ack = 1'b1; data = 32'h5555_5555;
    tick();
    check("flack_valid", 32'(valid), 32'd0);
    check("flack_addr", addr, 32'h48);
    check("flack_pc4", pc4, 32'h44);
    flush = 1'b0; data = 32'h6666_6666;
    tick();
    check("f48_instr", instr, 32'h6666_6666);
    check("f48_pc4", pc4, 32'h4C);
    check("f48_addr", addr, 32'h4C);
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, 32'd5);
    check("stall_cnt", stall_cnt, 32'd4);
`endif

    // Reset beats redirect
    ack = 1'b0; rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    check("rstwin_addr", addr, 32'd0);
    check("rstwin_req", 32'(req), 32'd0);
    check("rstwin_valid", 32'(valid), 32'd0);
    redirect = 1'b0;

    // PC wrap from 0xFFFF_FFFC
    b_rst = 1'b1;
    tick();
    check("wrap_addr0", b_addr, 32'hFFFF_FFFC);
    check("wrap_req", 32'(b_req), 32'd1);
    b_ack = 1'b1; b_data = 32'hABCD_0001;
    tick();
    check("wrap_pc4", b_pc4, 32'h0);
    check("wrap_addr", b_addr, 32'h0);
    check("wrap_imm", 32'(b_imm), 32'h0001);
`ifdef IF_PERF_CNT_EN
    check("wrap_fetch_cnt", b_fetch_cnt, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
